// File: rtl/gate_sweep_pkg.sv
// Shared types and 2-input truth tables for the gate sweeper.
// Truth tables are indexed by {b,a}: bit i is the expected output when stim == i.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_sweeper.sv
// Exhaustive in-hardware checker for an N_IN-input combinational gate: walks every
// input vector in ascending order, holds each for SETTLE cycles, then samples resp.
module gate_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int                     N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = TT_NOR,
  parameter int                     SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   IDX_LAST    = '1;
  localparam logic [N_IN:0]     ERR_MAX     = (N_IN + 1)'(1 << N_IN);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fv_q, fv_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              pass_q, pass_d;
  logic              mismatch;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ffi_d    = ffi_q;
    pass_d   = pass_q;
    // Case inequality so an X/Z response is flagged as a failure in simulation.
    mismatch = (resp !== TRUTH[idx_q]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          // Verdict uses err_d so the final vector's result is included.
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  // The vector index doubles as the stimulus: it only moves when leaving IDLE or SAMPLE.
  assign stim           = idx_q;
  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_sweeper.sv
// Bench for gate_sweeper: a NOR checker (SETTLE=2) and an XOR checker (SETTLE=1) driving a
// programmable gate whose truth table is chosen per test.
module tb_gate_sweeper;
  import gate_sweep_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       sel;
  logic [3:0] gfn;

  logic       start0, start1, resp0, resp1;
  logic [1:0] stim0, stim1, ffi0, ffi1;
  logic [2:0] err0, err1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;

  logic [1:0] m_stim, m_ffi;
  logic [2:0] m_err;
  logic       m_busy, m_done, m_pass, m_fv;

  int checks;
  int failures;

  assign start0 = go & ~sel;
  assign start1 = go & sel;
  assign resp0  = gfn[stim0];
  assign resp1  = gfn[stim1];

  assign m_stim = sel ? stim1 : stim0;
  assign m_ffi  = sel ? ffi1  : ffi0;
  assign m_err  = sel ? err1  : err0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_pass = sel ? pass1 : pass0;
  assign m_fv   = sel ? fv1   : fv0;

  gate_sweeper #(.N_IN(2), .TRUTH(TT_NOR), .SETTLE(2)) u_nor (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_idx(ffi0)
  );

  gate_sweeper #(.N_IN(2), .TRUTH(TT_XOR), .SETTLE(1)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: mismatches are the set bits of expected^actual truth tables.
  function automatic void model(input logic [3:0] truth, input logic [3:0] g,
                                output int err, output int ffi);
    logic [3:0] diff;
    diff = truth ^ g;
    err  = $countones(diff);
    ffi  = 0;
    for (int i = 3; i >= 0; i--) if (diff[i]) ffi = i;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_stim"}, m_stim, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_pass"}, m_pass, 0);
    check({tag, "_err"},  m_err,  0);
    check({tag, "_fv"},   m_fv,   0);
    check({tag, "_ffi"},  m_ffi,  0);
  endtask

  // One full sweep on instance s with gate g; verifies stimulus timing and the verdict.
  task automatic run_sweep(input logic s, input logic [3:0] g, input int exp_err,
                           input int exp_ffi, input string tag);
    int  settle, lat, j;
    bit  hit;
    settle = s ? 1 : 2;
    lat    = 4 * (settle + 1);
    sel    = s;
    gfn    = g;
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    j = 0; hit = 0;
    while (j <= lat + 4) begin
      if (m_done) begin hit = 1; break; end
      check({tag, "_stim_seq"}, m_stim, j / (settle + 1));
      check({tag, "_busy_seq"}, m_busy, 1);
      @(posedge clk); #1; j++;
    end
    check({tag, "_done_seen"}, hit, 1);
    check({tag, "_latency"}, j, lat);
    check({tag, "_err"}, m_err, exp_err);
    check({tag, "_fv"}, m_fv, exp_err != 0);
    if (exp_err != 0) check({tag, "_ffi"}, m_ffi, exp_ffi);
    check({tag, "_pass"}, m_pass, exp_err == 0);
    check({tag, "_busy_done"}, m_busy, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, m_done, 0);
      check({tag, "_pass_hold"}, m_pass, exp_err == 0);
      check({tag, "_stim_hold"}, m_stim, 3);
    end
  endtask

  typedef struct {
    logic       s;
    logic [3:0] g;
    int         err;
    int         ffi;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int e, f;
    checks = 0; failures = 0;
    rst_n = 1'b0; go = 1'b0; sel = 1'b0; gfn = TT_NOR;

    vecs[0] = '{1'b0, TT_NOR,  0, 0};
    vecs[1] = '{1'b0, 4'b0000, 1, 0};
    vecs[2] = '{1'b0, TT_OR,   4, 0};
    vecs[3] = '{1'b0, TT_AND,  2, 0};
    vecs[4] = '{1'b0, 4'b1111, 3, 1};
    vecs[5] = '{1'b0, TT_NAND, 2, 1};
    vecs[6] = '{1'b0, TT_XNOR, 1, 3};
    vecs[7] = '{1'b1, TT_XOR,  0, 0};
    vecs[8] = '{1'b1, TT_NOR,  3, 0};
    vecs[9] = '{1'b1, 4'b0000, 2, 1};

    #3;
    sel = 1'b0; #1; check_zero("reset_nor");
    sel = 1'b1; #1; check_zero("reset_xor");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_sweep(vecs[i].s, vecs[i].g, vecs[i].err, vecs[i].ffi, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic       s;
      logic [3:0] g;
      s = 1'($urandom_range(0, 1));
      g = 4'($urandom_range(0, 15));
      model(s ? TT_XOR : TT_NOR, g, e, f);
      run_sweep(s, g, e, f, $sformatf("rand%0d", i));
    end

    // Start pulses while busy, during SAMPLE, during the done cycle, then in IDLE.
    sel = 1'b0; gfn = 4'b0000;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      go = (c == 0 || c == 3 || c == 12 || c == 13 || c == 14);
      @(posedge clk); #1;
      check($sformatf("busy_start_done_c%0d", c), m_done, (c == 12 || c == 26));
      if (c == 12) begin
        check("busy_start_err", m_err, 1);
        check("busy_start_pass", m_pass, 0);
      end
      if (c == 13) check("busy_start_ignored", m_busy, 0);
      if (c == 14) begin
        check("restart_busy", m_busy, 1);
        check("restart_stim", m_stim, 0);
        check("restart_err", m_err, 0);
        check("restart_fv", m_fv, 0);
      end
    end
    @(negedge clk); go = 1'b0;

    // Asynchronous reset in the middle of vector 2 while an error is recorded.
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    repeat (7) @(posedge clk);
    #1; check("pre_rst_stim", m_stim, 2);
    check("pre_rst_err", m_err, 1);
    #1; rst_n = 1'b0;
    #1; check_zero("async_rst");
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", m_done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle", m_done | m_busy, 0);
    end
    run_sweep(1'b0, TT_NOR, 0, 0, "rst_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
